sobel_tx_buffer: RTL and testbench
==================================

// Module: sobel_tx_buffer
// PURPOSE
//  Output stage directly downstream of sobel_filter. It absorbs the PCIEPacket stream
//  produced by the filter, which has no backpressure, into a FIFO, and presents the
//  packets to the PCIe TX path over a valid/ready handshake.
//  It raises an early throttle so the host-side source can stop issuing input
//  before the filter pipeline overruns the buffer. It also keeps a sent-packet
//  count and a sticky overflow flag.
// PARAMETERS
//  DEPTH         64   FIFO entries; power of two, >= 8
//  AFULL_MARGIN  8    entries reserved for packets still in flight inside sobel_filter
//  CNT_W         32   width of the sent-packet counter
// PORTS
//  clk              in   1     system clock; single clock domain
//  rst              in   1     synchronous reset, active high
//  pcie_packet_in   in   PCIEPacket  filter output; .valid qualifies .data (512b)
//  tx_data          out  512   packet payload to PCIe TX
//  tx_valid         out  1     tx_data holds a valid packet
//  tx_ready         in   1     TX accepts; transfer when tx_valid && tx_ready
//  in_throttle      out  1     stop feeding sobel_filter
//  overflow         out  1     sticky: a packet was dropped
//  clear_overflow   in   1     one-cycle pulse that clears overflow
//  level            out  $clog2(DEPTH+1)  entries held, including the output register
//  pkt_count        out  CNT_W packets transferred on TX since reset
// BEHAVIOUR
//  Reset: one clock, rst=1, synchronous. Resulting values:
//   - tx_valid=0, tx_data=0, in_throttle=0, overflow=0, level=0, pkt_count=0.
//   - Pointers cleared; buffered contents discarded. Reset mid-transfer flushes the FIFO.
//  Push: on pcie_packet_in.valid=1, if level<DEPTH or a pop happens the same cycle.
//  Pop: on tx_valid && tx_ready.
//  Storage: show-ahead FIFO, DEPTH entries total. A DEPTH-1 RAM plus one output register.
//  Latency:
//   - A push into an empty buffer gives tx_valid=1 on the next cycle, with tx_data equal
//     to that packet. The total is one cycle.
//   - After a pop, the next entry appears in the output register on the following cycle.
//     Back-to-back pops sustain 1 packet/cycle.
//  Output hold: while tx_valid && !tx_ready, tx_data and tx_valid stay stable.
//   tx_valid never drops without a transfer.
//  Ordering: packets leave in arrival order; no reordering, no duplication.
//  Counting: level tracks the push/pop count.
//   - +1 on push only, -1 on pop only, unchanged on both or neither.
//   - It never exceeds DEPTH and never goes below 0.
//  Throttle: in_throttle = (level >= DEPTH-AFULL_MARGIN). It is registered from the
//   next-state level, so it asserts in the same cycle level reaches the threshold.
//  Full: push with level==DEPTH and no simultaneous pop. The packet is dropped, level is
//   unchanged, and overflow is set on the next cycle.
//  Full plus pop: with level==DEPTH and a simultaneous pop, the push is accepted.
//  Empty plus push: with level==0 and a simultaneous push, no pop is possible
//   (tx_valid=0) and the push is accepted.
//  Overflow vs clear: if clear_overflow and a new drop occur in the same cycle, set wins
//   and overflow stays 1.
//  pkt_count: +1 per TX transfer; wraps modulo 2^CNT_W with no saturation.
//  Pointers: RAM read and write pointers are $clog2(DEPTH-1)-bit modulo counters.
//   Wrap-around is covered by the level-based full and empty decisions.
//  X-handling: pcie_packet_in.data is ignored when .valid=0. The RAM is not written.
// STRUCTURE
//  Shared package (sobel_pkg):
//   - PCIEPacket typedef, struct {logic valid; logic [511:0] data;}.
//   - PCIE_DATA_W=512.
//  Sub-module sobel_tx_ram: simple dual-port RAM.
//   - Interface: DEPTH-1 x 512, one write port, one read port, registered read.
//   - No reset on the array.
//  Top level holds the pointers, level, output register and handshake, throttle,
//   overflow and counter.
// TESTING
//  T1 Single packet: push data=0xA5..A5 with tx_ready=1.
//   -> next cycle tx_valid=1, tx_data=0xA5..A5; the cycle after, level=0 and pkt_count=1.
//  T2 Stall: push 10 packets (data=i) with tx_ready=0.
//   -> level=10 and tx_data=0 held stable.
//   -> Then tx_ready=1: data 0..9 come out on 10 consecutive cycles; pkt_count=10.
//  T3 Throttle: with tx_ready=0, push 55 packets (DEPTH=64, margin 8).
//   -> in_throttle=0 at level 55.
//   -> The 56th push makes in_throttle=1 in the same cycle level=56.
//   -> One pop returns in_throttle to 0.
//  T4 Overflow: with tx_ready=0, push 66 packets.
//   -> level=64 and overflow=1.
//   -> Draining yields data 0..63 only; clear_overflow pulse -> overflow=0.
//  T5 Full with simultaneous push and pop: at level=64, push and pop in one cycle.
//   -> level stays 64, overflow stays 0, the new packet is delivered last.
//  T6 Mid-reset: rst=1 for one cycle while level=20 and tx_valid=1.
//   -> Next cycle all outputs are zero.
//   -> A subsequent push is delivered with one-cycle latency.

Source files
------------

// File: rtl/sobel_pkg.sv
// Shared types for the sobel output path.
// Packet bundle handed from sobel_filter downstream.
package sobel_pkg;

   localparam int PCIE_DATA_W = 512;

   typedef struct packed {
      logic                   valid;
      logic [PCIE_DATA_W-1:0] data;
   } PCIEPacket;

endpackage

// File: rtl/sobel_tx_ram.sv
// Simple dual-port RAM for the TX buffer.
// Registered read, read-first on address collision, no array reset.
module sobel_tx_ram #(
   parameter int WORDS = 63,
   parameter int AW    = 6,
   parameter int DW    = 512
) (
   input  logic          clk,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  logic [DW-1:0] wr_data,
   input  logic          rd_en,
   input  logic [AW-1:0] rd_addr,
   output logic [DW-1:0] rd_data
);

   logic [DW-1:0] mem [WORDS];

   // write and registered read share the clock; read returns old data
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
      if (rd_en) rd_data <= mem[rd_addr];
   end

endmodule

// File: rtl/sobel_tx_buffer.sv
// Show-ahead TX buffer between sobel_filter and the PCIe TX path.
// RAM holds the backlog; output word is either a bypass flop or RAM read data.
module sobel_tx_buffer
   import sobel_pkg::*;
#(
   parameter int DEPTH        = 64,
   parameter int AFULL_MARGIN = 8,
   parameter int CNT_W        = 32
) (
   input  logic                       clk,
   input  logic                       rst,
   input  PCIEPacket                  pcie_packet_in,
   output logic [PCIE_DATA_W-1:0]     tx_data,
   output logic                       tx_valid,
   input  logic                       tx_ready,
   output logic                       in_throttle,
   output logic                       overflow,
   input  logic                       clear_overflow,
   output logic [$clog2(DEPTH+1)-1:0] level,
   output logic [CNT_W-1:0]           pkt_count
);

   localparam int AW = $clog2(DEPTH-1);
   localparam int LW = $clog2(DEPTH+1);

   localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);
   localparam logic [LW-1:0] LVL_THR  = LW'(DEPTH - AFULL_MARGIN);
   localparam logic [LW-1:0] LVL_ONE  = LW'(1);
   localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH - 2);
   localparam logic [AW-1:0] PTR_ONE  = AW'(1);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [LW-1:0] ram_lvl;
   logic [LW-1:0] ram_lvl_nxt;
   logic [LW-1:0] level_nxt;
   logic          out_valid;
   logic          sel_byp;

   logic [PCIE_DATA_W-1:0] byp_q;
   logic [PCIE_DATA_W-1:0] ram_q;

   logic pop;
   logic push;
   logic drop;
   logic load;
   logic ram_rd;
   logic ram_wr;
   logic byp;

   // handshake decisions and next-state occupancy
   always_comb begin
      pop    = out_valid & tx_ready;
      push   = pcie_packet_in.valid & ((level != LVL_FULL) | pop);
      drop   = pcie_packet_in.valid & ~push;
      load   = ~out_valid | pop;
      ram_rd = load & (ram_lvl != '0);
      byp    = load & (ram_lvl == '0) & push;
      ram_wr = push & ~byp;

      level_nxt = level;
      unique case ({push, pop})
         2'b10:   level_nxt = level + LVL_ONE;
         2'b01:   level_nxt = level - LVL_ONE;
         default: level_nxt = level;
      endcase

      ram_lvl_nxt = ram_lvl;
      unique case ({ram_wr, ram_rd})
         2'b10:   ram_lvl_nxt = ram_lvl + LVL_ONE;
         2'b01:   ram_lvl_nxt = ram_lvl - LVL_ONE;
         default: ram_lvl_nxt = ram_lvl;
      endcase
   end

   sobel_tx_ram #(
      .WORDS (DEPTH - 1),
      .AW    (AW),
      .DW    (PCIE_DATA_W)
   ) u_ram (
      .clk     (clk),
      .wr_en   (ram_wr),
      .wr_addr (wr_ptr),
      .wr_data (pcie_packet_in.data),
      .rd_en   (ram_rd),
      .rd_addr (rd_ptr),
      .rd_data (ram_q)
   );

   // pointers, occupancy, output word select, flags and counter
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         ram_lvl     <= '0;
         level       <= '0;
         out_valid   <= 1'b0;
         sel_byp     <= 1'b1;
         byp_q       <= '0;
         in_throttle <= 1'b0;
         overflow    <= 1'b0;
         pkt_count   <= '0;
      end else begin
         if (ram_wr)
            wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PTR_ONE;
         if (ram_rd)
            rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + PTR_ONE;
         ram_lvl     <= ram_lvl_nxt;
         level       <= level_nxt;
         in_throttle <= (level_nxt >= LVL_THR);
         if (load) begin
            out_valid <= ram_rd | byp;
            if (ram_rd)
               sel_byp <= 1'b0;
            else if (byp)
               sel_byp <= 1'b1;
         end
         if (byp)
            byp_q <= pcie_packet_in.data;
         if (drop)
            overflow <= 1'b1;
         else if (clear_overflow)
            overflow <= 1'b0;
         if (pop)
            pkt_count <= pkt_count + CNT_ONE;
      end
   end

   assign tx_valid = out_valid;
   assign tx_data  = sel_byp ? byp_q : ram_q;

endmodule

// File: tb/tb_sobel_tx_buffer.sv
// Directed bench for sobel_tx_buffer.
// Hand-computed expectations for each scenario.
module tb_sobel_tx_buffer;
   import sobel_pkg::*;

   logic            clk = 1'b0;
   logic            rst;
   PCIEPacket       pkt;
   logic [511:0]    tx_data;
   logic            tx_valid;
   logic            tx_ready;
   logic            in_throttle;
   logic            overflow;
   logic            clear_overflow;
   logic [6:0]      level;
   logic [31:0]     pkt_count;

   int n_chk = 0;
   int n_bad = 0;

   sobel_tx_buffer #(
      .DEPTH        (64),
      .AFULL_MARGIN (8),
      .CNT_W        (32)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .pcie_packet_in (pkt),
      .tx_data        (tx_data),
      .tx_valid       (tx_valid),
      .tx_ready       (tx_ready),
      .in_throttle    (in_throttle),
      .overflow       (overflow),
      .clear_overflow (clear_overflow),
      .level          (level),
      .pkt_count      (pkt_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag,
                      input logic [511:0] got,
                      input logic [511:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      rst = 1'b1;
      tick;
      rst = 1'b0;
   endtask

   task automatic push_seq(input int n, input logic rdy);
      for (int i = 0; i < n; i++) begin
         pkt.valid = 1'b1;
         pkt.data  = 512'(i);
         tx_ready  = rdy;
         tick;
      end
      pkt.valid = 1'b0;
      pkt.data  = '0;
   endtask

   logic [511:0] a5;
   logic [511:0] exp_d;

   initial begin
      rst            = 1'b1;
      pkt            = '0;
      tx_ready       = 1'b0;
      clear_overflow = 1'b0;
      a5             = {64{8'hA5}};
      tick;
      chk("rst_valid", 512'(tx_valid), 512'(0));
      chk("rst_data", tx_data, 512'(0));
      chk("rst_thr", 512'(in_throttle), 512'(0));
      chk("rst_ovf", 512'(overflow), 512'(0));
      chk("rst_level", 512'(level), 512'(0));
      chk("rst_cnt", 512'(pkt_count), 512'(0));
      rst = 1'b0;

      // T1 single packet
      pkt.valid = 1'b1;
      pkt.data  = a5;
      tx_ready  = 1'b1;
      tick;
      pkt.valid = 1'b0;
      chk("t1_valid", 512'(tx_valid), 512'(1));
      chk("t1_data", tx_data, a5);
      chk("t1_level1", 512'(level), 512'(1));
      tick;
      chk("t1_level0", 512'(level), 512'(0));
      chk("t1_cnt", 512'(pkt_count), 512'(1));
      chk("t1_empty", 512'(tx_valid), 512'(0));

      // T2 stall then burst drain
      do_reset;
      push_seq(10, 1'b0);
      chk("t2_level", 512'(level), 512'(10));
      chk("t2_hold_v", 512'(tx_valid), 512'(1));
      chk("t2_hold_d", tx_data, 512'(0));
      tick;
      chk("t2_hold_d2", tx_data, 512'(0));
      chk("t2_hold_v2", 512'(tx_valid), 512'(1));
      tx_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         chk("t2_drain_v", 512'(tx_valid), 512'(1));
         chk("t2_drain_d", tx_data, 512'(i));
         tick;
      end
      tx_ready = 1'b0;
      chk("t2_cnt", 512'(pkt_count), 512'(10));
      chk("t2_level0", 512'(level), 512'(0));
      chk("t2_empty", 512'(tx_valid), 512'(0));

      // T3 throttle threshold
      do_reset;
      push_seq(55, 1'b0);
      chk("t3_lvl55", 512'(level), 512'(55));
      chk("t3_thr55", 512'(in_throttle), 512'(0));
      push_seq(1, 1'b0);
      chk("t3_lvl56", 512'(level), 512'(56));
      chk("t3_thr56", 512'(in_throttle), 512'(1));
      tx_ready = 1'b1;
      tick;
      tx_ready = 1'b0;
      chk("t3_lvl_pop", 512'(level), 512'(55));
      chk("t3_thr_pop", 512'(in_throttle), 512'(0));

      // T4 overflow, drop, set beats clear
      do_reset;
      push_seq(64, 1'b0);
      chk("t4_full_ovf0", 512'(overflow), 512'(0));
      push_seq(2, 1'b0);
      chk("t4_level", 512'(level), 512'(64));
      chk("t4_ovf", 512'(overflow), 512'(1));
      pkt.valid      = 1'b1;
      pkt.data       = 512'(999);
      clear_overflow = 1'b1;
      tick;
      pkt.valid      = 1'b0;
      clear_overflow = 1'b0;
      chk("t4_set_wins", 512'(overflow), 512'(1));
      chk("t4_level2", 512'(level), 512'(64));
      tx_ready = 1'b1;
      for (int i = 0; i < 64; i++) begin
         chk("t4_drain_d", tx_data, 512'(i));
         tick;
      end
      tx_ready = 1'b0;
      chk("t4_empty", 512'(tx_valid), 512'(0));
      chk("t4_level0", 512'(level), 512'(0));
      clear_overflow = 1'b1;
      tick;
      clear_overflow = 1'b0;
      chk("t4_clear", 512'(overflow), 512'(0));

      // T5 full with simultaneous push and pop
      do_reset;
      push_seq(64, 1'b0);
      chk("t5_level", 512'(level), 512'(64));
      pkt.valid = 1'b1;
      pkt.data  = 512'(1000);
      tx_ready  = 1'b1;
      tick;
      pkt.valid = 1'b0;
      tx_ready  = 1'b0;
      chk("t5_level_kept", 512'(level), 512'(64));
      chk("t5_ovf0", 512'(overflow), 512'(0));
      tx_ready = 1'b1;
      for (int i = 1; i <= 64; i++) begin
         exp_d = (i == 64) ? 512'(1000) : 512'(i);
         chk("t5_drain_d", tx_data, exp_d);
         tick;
      end
      tx_ready = 1'b0;
      chk("t5_empty", 512'(tx_valid), 512'(0));
      chk("t5_cnt", 512'(pkt_count), 512'(65));

      // T6 reset while holding data
      do_reset;
      push_seq(20, 1'b0);
      chk("t6_level", 512'(level), 512'(20));
      chk("t6_valid", 512'(tx_valid), 512'(1));
      rst = 1'b1;
      tick;
      rst = 1'b0;
      chk("t6_rst_v", 512'(tx_valid), 512'(0));
      chk("t6_rst_d", tx_data, 512'(0));
      chk("t6_rst_lvl", 512'(level), 512'(0));
      chk("t6_rst_thr", 512'(in_throttle), 512'(0));
      pkt.valid = 1'b1;
      pkt.data  = 512'h77;
      tick;
      pkt.valid = 1'b0;
      chk("t6_push_v", 512'(tx_valid), 512'(1));
      chk("t6_push_d", tx_data, 512'h77);
      chk("t6_push_lvl", 512'(level), 512'(1));

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
